snake_game_ctrl: RTL and testbench
==================================

// Module: snake_game_ctrl
// PURPOSE
//  Game sequencer for the snake design. Conditions the four raw buttons, arbitrates direction
//  requests with reversal rejection, times game steps, and handshakes each step with the snake
//  datapath (move/grow/collision check). Tracks game state IDLE/RUN/WAIT/OVER.
//  Sits between the button pins and the snake datapath in top.
// PARAMETERS
//  DEBOUNCE_CYC  120_000    cycles a synced button level must be stable to be accepted (10 ms @ 12 MHz)
//  STEP_CYC      1_200_000  cycles between step requests while running (100 ms @ 12 MHz)
// PORTS
//  clk        in   1   system clock, 12 MHz
//  rst_n      in   1   asynchronous reset, active-low
//  btn_up     in   1   raw button, active-high, asynchronous
//  btn_left   in   1   raw button, active-high, asynchronous
//  btn_right  in   1   raw button, active-high, asynchronous
//  btn_down   in   1   raw button, active-high, asynchronous
//  step_done  in   1   datapath finished the requested step (1-cycle pulse)
//  collision  in   1   datapath collision flag, valid when step_done=1
//  step       out  1   1-cycle step request to datapath
//  dir        out  2   committed direction: 00 right, 01 up, 10 left, 11 down
//  state      out  2   00 IDLE, 01 RUN, 10 WAIT, 11 OVER
//  game_over  out  1   high while state==OVER
//  steps      out  16  completed non-colliding steps, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (rst_n low, async): step=0, dir=00, state=IDLE, game_over=0, steps=0. Synchronizers,
//   debounce counters, tick counter and pending direction all clear. Valid from any state.
//  Conditioning, per button: 2-FF synchronizer, then debounce. Debounced level changes only after
//   the synced level differs from it for DEBOUNCE_CYC consecutive cycles; any return resets the count.
//   press = 1-cycle pulse on debounced rising edge. Releases generate nothing.
//  Arbitration: simultaneous presses resolve by priority up > left > right > down; others dropped.
//  Reversal rule: request rejected if req == dir ^ 2'b10 (compare to committed dir, not pending).
//  Pending dir (dir_pend): loads dir on entry to RUN; accepted presses in RUN/WAIT overwrite it.
//   Last accepted press wins.
//  FSM:
//   IDLE: winning press -> dir=req, dir_pend=req, tick=0, steps=0, go RUN. No reversal check.
//   RUN: tick counts 0..STEP_CYC-1. On the cycle tick==STEP_CYC-1: step=1 registered next cycle,
//        dir<=dir_pend in that same cycle, go WAIT, tick=0.
//   WAIT: tick frozen at 0, step low. On step_done: collision=1 -> OVER, else steps+=1
//         (saturating) -> RUN.
//   OVER: game_over=1, dir/steps held. Any press -> IDLE; that press is consumed, does not start a game.
//  step_done outside WAIT: ignored. Presses in OVER never alter dir.
//  Step period: exactly STEP_CYC cycles from RUN entry to step, plus datapath latency per step.
//  step never asserts on two consecutive cycles. WAIT has no timeout.
// TESTING (bench uses DEBOUNCE_CYC=4, STEP_CYC=10)
//  1 Reset; hold btn_right 10 cycles -> state RUN, dir=00; step pulses 10 cycles after RUN entry.
//    Answer step_done 2 cycles later -> steps=1, state RUN.
//  2 Toggle btn_up every 2 cycles for 30 cycles in IDLE -> no press, state stays IDLE, dir=00.
//  3 Running dir=00: press left -> next step keeps dir=00. Press up, then left, within one interval
//    -> next step dir=01 (left rejected vs committed right).
//  4 IDLE: assert btn_up and btn_down in the same cycle -> RUN with dir=01.
//  5 In WAIT: step_done=1 with collision=1 -> state OVER, game_over=1, no further step for 50 cycles.
//    Press btn_down -> IDLE, dir unchanged.
//  6 Pull rst_n low mid-WAIT for 1 cycle -> all outputs return to reset values immediately.
//    Late step_done -> ignored.

Source files
------------

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: button conditioning, direction arbitration and step sequencing
// for the snake datapath (IDLE/RUN/WAIT/OVER).
`default_nettype none

module snake_game_ctrl #(
  parameter int DEBOUNCE_CYC = 120_000,
  parameter int STEP_CYC     = 1_200_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_down,
  input  logic        step_done,
  input  logic        collision,
  output logic        step,
  output logic [1:0]  dir,
  output logic [1:0]  state,
  output logic        game_over,
  output logic [15:0] steps
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int TICK_W = $clog2(STEP_CYC + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_WAIT = 2'b10,
    ST_OVER = 2'b11
  } state_t;

  state_t state_q, state_nxt;

  // Bit order sets arbitration priority: up, left, right, down.
  logic [3:0] btn_raw;
  logic [3:0] sync1, sync2, db, db_prev, press;
  logic [DB_W-1:0] db_cnt [4];

  assign btn_raw = {btn_down, btn_right, btn_left, btn_up};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1[i]   <= 1'b0;
        sync2[i]   <= 1'b0;
        db[i]      <= 1'b0;
        db_prev[i] <= 1'b0;
        db_cnt[i]  <= '0;
      end else begin
        sync1[i]   <= btn_raw[i];
        sync2[i]   <= sync1[i];
        db_prev[i] <= db[i];
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db[i]     <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press = db & ~db_prev;

  logic       any_press;
  logic       accept;
  logic [1:0] req;
  logic [1:0] dir_pend;
  logic [TICK_W-1:0] tick;
  logic       tick_done;

  always_comb begin
    req = 2'b00;
    if (press[0])      req = 2'b01;
    else if (press[1]) req = 2'b10;
    else if (press[2]) req = 2'b00;
    else if (press[3]) req = 2'b11;
  end

  assign any_press = |press;
  assign accept    = any_press && (req != (dir ^ 2'b10));
  assign tick_done = (tick == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (any_press) state_nxt = ST_RUN;
      ST_RUN:  if (tick_done) state_nxt = ST_WAIT;
      ST_WAIT: if (step_done) state_nxt = collision ? ST_OVER : ST_RUN;
      ST_OVER: if (any_press) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step     <= 1'b0;
      dir      <= 2'b00;
      dir_pend <= 2'b00;
      tick     <= '0;
      steps    <= 16'h0000;
    end else begin
      step <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tick <= '0;
          if (any_press) begin
            dir      <= req;
            dir_pend <= req;
            steps    <= 16'h0000;
          end
        end
        ST_RUN: begin
          if (accept) dir_pend <= req;
          if (tick_done) begin
            step <= 1'b1;
            dir  <= dir_pend;
            tick <= '0;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        ST_WAIT: begin
          tick <= '0;
          if (accept) dir_pend <= req;
          if (step_done && !collision && steps != 16'hFFFF)
            steps <= steps + 16'h0001;
        end
        default: ;
      endcase
    end
  end

  assign state     = state_q;
  assign game_over = (state_q == ST_OVER);

endmodule

`default_nettype wire

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with short debounce/step periods.
`default_nettype none

module tb_snake_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_up, btn_left, btn_right, btn_down;
  logic        step_done, collision;
  logic        step;
  logic [1:0]  dir;
  logic [1:0]  state;
  logic        game_over;
  logic [15:0] steps;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_WAIT = 2'b10, S_OVER = 2'b11;

  snake_game_ctrl #(.DEBOUNCE_CYC(4), .STEP_CYC(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_left(btn_left), .btn_right(btn_right), .btn_down(btn_down),
    .step_done(step_done), .collision(collision),
    .step(step), .dir(dir), .state(state), .game_over(game_over), .steps(steps)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_state(input string tag, input logic [1:0] s, input int budget);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, {30'b0, state}, {30'b0, s});
  endtask

  task automatic wait_step(input string tag, input int budget, output int n);
    n = 0;
    while (step !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, {31'b0, step}, 32'd1);
  endtask

  initial begin
    int n;
    int step_cnt;
    rst_n = 1'b0;
    {btn_up, btn_left, btn_right, btn_down} = 4'b0;
    step_done = 1'b0;
    collision = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_state", {30'b0, state}, 32'd0);
    check_val("rst_dir", {30'b0, dir}, 32'd0);
    check_val("rst_step", {31'b0, step}, 32'd0);
    check_val("rst_over", {31'b0, game_over}, 32'd0);
    check_val("rst_steps", {16'b0, steps}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Bouncing button never survives debounce.
    for (int i = 0; i < 15; i++) begin
      btn_up = ~btn_up;
      repeat (2) @(negedge clk);
    end
    btn_up = 1'b0;
    repeat (8) @(negedge clk);
    check_val("bounce_state", {30'b0, state}, {30'b0, S_IDLE});
    check_val("bounce_dir", {30'b0, dir}, 32'd0);

    // Start game with right; step exactly STEP_CYC cycles after RUN entry.
    btn_right = 1'b1;
    wait_state("start_run", S_RUN, 20);
    btn_right = 1'b0;
    check_val("start_dir", {30'b0, dir}, 32'd0);
    wait_step("step1_seen", 30, n);
    check_val("step1_lat", n, 32'd10);
    @(negedge clk);
    check_val("step_1cyc", {31'b0, step}, 32'd0);
    check_val("wait_state", {30'b0, state}, {30'b0, S_WAIT});
    @(negedge clk);
    step_done = 1'b1;
    @(negedge clk);
    step_done = 1'b0;
    check_val("steps1", {16'b0, steps}, 32'd1);
    check_val("back_run", {30'b0, state}, {30'b0, S_RUN});

    // Reversal left against committed right is rejected.
    btn_left = 1'b1;
    repeat (8) @(negedge clk);
    btn_left = 1'b0;
    wait_step("step2_seen", 30, n);
    check_val("rev_dir", {30'b0, dir}, 32'd0);
    repeat (10) @(negedge clk);

    // Up then left in one interval: left checked against committed right.
    btn_up = 1'b1;
    repeat (3) @(negedge clk);
    btn_left = 1'b1;
    repeat (2) @(negedge clk);
    step_done = 1'b1;
    @(negedge clk);
    step_done = 1'b0;
    check_val("steps2", {16'b0, steps}, 32'd2);
    repeat (5) @(negedge clk);
    btn_up = 1'b0;
    btn_left = 1'b0;
    wait_step("step3_seen", 30, n);
    check_val("last_win_dir", {30'b0, dir}, 32'd1);

    // Collision ends the game; no steps while OVER.
    @(negedge clk);
    step_done = 1'b1;
    collision = 1'b1;
    @(negedge clk);
    step_done = 1'b0;
    collision = 1'b0;
    check_val("over_state", {30'b0, state}, {30'b0, S_OVER});
    check_val("over_flag", {31'b0, game_over}, 32'd1);
    check_val("over_steps", {16'b0, steps}, 32'd2);
    step_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (step) step_cnt++;
    end
    check_val("over_nostep", step_cnt, 32'd0);
    btn_down = 1'b1;
    wait_state("over_to_idle", S_IDLE, 20);
    check_val("over_dir_held", {30'b0, dir}, 32'd1);
    check_val("idle_flag", {31'b0, game_over}, 32'd0);
    btn_down = 1'b0;
    repeat (10) @(negedge clk);
    check_val("consumed_idle", {30'b0, state}, {30'b0, S_IDLE});

    // Simultaneous up+down: up has priority.
    btn_up = 1'b1;
    btn_down = 1'b1;
    wait_state("simul_run", S_RUN, 20);
    check_val("simul_dir", {30'b0, dir}, 32'd1);
    check_val("start_clr_steps", {16'b0, steps}, 32'd0);
    btn_up = 1'b0;
    btn_down = 1'b0;

    // Async reset mid-WAIT, then a late step_done is ignored.
    wait_step("step4_seen", 30, n);
    @(negedge clk);
    check_val("pre_rst_wait", {30'b0, state}, {30'b0, S_WAIT});
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_state", {30'b0, state}, 32'd0);
    check_val("arst_dir", {30'b0, dir}, 32'd0);
    check_val("arst_step", {31'b0, step}, 32'd0);
    check_val("arst_over", {31'b0, game_over}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step_done = 1'b1;
    @(negedge clk);
    step_done = 1'b0;
    repeat (3) @(negedge clk);
    check_val("late_done_state", {30'b0, state}, {30'b0, S_IDLE});
    check_val("late_done_step", {31'b0, step}, 32'd0);
    check_val("late_done_steps", {16'b0, steps}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
